// File: rtl/quad_encoder_regs.sv
// Dual-channel quadrature encoder front end: synchronize, filter, decode, count,
// and expose positions, windowed speeds and error counts on a 32-bit read port.
`timescale 1ns/1ps

module quad_encoder_chan #(
  parameter int FILT_LEN = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        enc_a_i,
  input  logic        enc_b_i,
  input  logic        win_end_i,
  output logic [31:0] pos_o,
  output logic [31:0] speed_o,
  output logic [15:0] err_o,
  output logic        primed_o
);

  localparam int CW = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILT_LEN - 1);

  // Bit 1 carries phase A, bit 0 carries phase B.
  logic [1:0]    sync1_q;
  logic [1:0]    sync2_q;
  logic [1:0]    filt_q;
  logic [1:0]    filt_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];
  logic [1:0]    prev_q;
  logic [1:0]    prev_d;
  logic          primed_q;
  logic          primed_d;
  logic [31:0]   pos_q;
  logic [31:0]   pos_d;
  logic [31:0]   acc_q;
  logic [31:0]   acc_d;
  logic [31:0]   speed_q;
  logic [31:0]   speed_d;
  logic [15:0]   err_q;
  logic [15:0]   err_d;
  logic [31:0]   inc_s;
  logic          illegal_s;

  // Per-pin stability filter: a level is taken once it has been seen FILT_LEN times in a row.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      filt_d[i] = filt_q[i];
      cnt_d[i]  = '0;
      if (sync2_q[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] == CNT_LAST) begin
        filt_d[i] = sync2_q[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + CW'(1);
      end
    end
  end

  // Decoder; the first change after reset only primes the previous state.
  always_comb begin
    inc_s     = 32'd0;
    illegal_s = 1'b0;
    prev_d    = prev_q;
    primed_d  = primed_q;
    if (filt_q != prev_q) begin
      prev_d = filt_q;
      if (primed_q) begin
        case ({prev_q, filt_q})
          4'b00_10, 4'b10_11, 4'b11_01, 4'b01_00: inc_s = 32'd1;
          4'b00_01, 4'b01_11, 4'b11_10, 4'b10_00: inc_s = 32'hFFFF_FFFF;
          default:                                illegal_s = 1'b1;
        endcase
      end else begin
        primed_d = 1'b1;
      end
    end else begin
      prev_d = prev_q;
    end
  end

  // Position, window accumulator, speed snapshot and saturating error count.
  always_comb begin
    pos_d = pos_q + inc_s;
    if (win_end_i) begin
      speed_d = acc_q + inc_s;
      acc_d   = 32'd0;
    end else begin
      speed_d = speed_q;
      acc_d   = acc_q + inc_s;
    end
    if (illegal_s && (err_q != 16'hFFFF)) begin
      err_d = err_q + 16'd1;
    end else begin
      err_d = err_q;
    end
  end

  // State registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sync1_q  <= 2'b00;
      sync2_q  <= 2'b00;
      filt_q   <= 2'b00;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      prev_q   <= 2'b00;
      primed_q <= 1'b0;
      pos_q    <= 32'd0;
      acc_q    <= 32'd0;
      speed_q  <= 32'd0;
      err_q    <= 16'd0;
    end else begin
      sync1_q  <= {enc_a_i, enc_b_i};
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      prev_q   <= prev_d;
      primed_q <= primed_d;
      pos_q    <= pos_d;
      acc_q    <= acc_d;
      speed_q  <= speed_d;
      err_q    <= err_d;
    end
  end

  assign pos_o    = pos_q;
  assign speed_o  = speed_q;
  assign err_o    = err_q;
  assign primed_o = primed_q;

endmodule

module quad_encoder_regs #(
  parameter int SAMPLE_DIV = 500000,
  parameter int FILT_LEN   = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        EncA_L,
  input  logic        EncB_L,
  input  logic        EncA_R,
  input  logic        EncB_R,
  input  logic [7:0]  DataAddr,
  output logic [31:0] DataToRPi,
  output logic        Tick
);

  localparam int DW = $clog2(SAMPLE_DIV);
  localparam logic [DW-1:0] DIV_LAST = DW'(SAMPLE_DIV - 1);
  localparam logic [31:0]   ID_WORD  = 32'hCA4B_0714;

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic [31:0]   wincnt_q;
  logic [31:0]   wincnt_d;
  logic          tick_q;
  logic          tick_d;
  logic          win_end_s;
  logic [31:0]   pos_l_s;
  logic [31:0]   pos_r_s;
  logic [31:0]   speed_l_s;
  logic [31:0]   speed_r_s;
  logic [15:0]   err_l_s;
  logic [15:0]   err_r_s;
  logic          primed_l_s;
  logic          primed_r_s;

  quad_encoder_chan #(.FILT_LEN(FILT_LEN)) u_chan_l (
    .Clk       (Clk),
    .Reset     (Reset),
    .enc_a_i   (EncA_L),
    .enc_b_i   (EncB_L),
    .win_end_i (win_end_s),
    .pos_o     (pos_l_s),
    .speed_o   (speed_l_s),
    .err_o     (err_l_s),
    .primed_o  (primed_l_s)
  );

  quad_encoder_chan #(.FILT_LEN(FILT_LEN)) u_chan_r (
    .Clk       (Clk),
    .Reset     (Reset),
    .enc_a_i   (EncA_R),
    .enc_b_i   (EncB_R),
    .win_end_i (win_end_s),
    .pos_o     (pos_r_s),
    .speed_o   (speed_r_s),
    .err_o     (err_r_s),
    .primed_o  (primed_r_s)
  );

  // The window closes on the last count; Tick and speed snapshots land on the same edge.
  assign win_end_s = (div_q == DIV_LAST);

  // Window divider and window counter next state.
  always_comb begin
    tick_d = win_end_s;
    if (win_end_s) begin
      div_d    = '0;
      wincnt_d = wincnt_q + 32'd1;
    end else begin
      div_d    = div_q + DW'(1);
      wincnt_d = wincnt_q;
    end
  end

  // Window registers.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      div_q    <= '0;
      wincnt_q <= 32'd0;
      tick_q   <= 1'b0;
    end else begin
      div_q    <= div_d;
      wincnt_q <= wincnt_d;
      tick_q   <= tick_d;
    end
  end

  assign Tick = tick_q;

  // Read mux over registered values.
  always_comb begin
    DataToRPi = 32'd0;
    case (DataAddr)
      8'h00:   DataToRPi = ID_WORD;
      8'h01:   DataToRPi = pos_l_s;
      8'h02:   DataToRPi = pos_r_s;
      8'h03:   DataToRPi = speed_l_s;
      8'h04:   DataToRPi = speed_r_s;
      8'h05:   DataToRPi = {err_l_s, err_r_s};
      8'h06:   DataToRPi = wincnt_q;
      8'h07:   DataToRPi = {29'd0, primed_r_s, primed_l_s, 1'b1};
      default: DataToRPi = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_quad_encoder_regs.sv
// Self-checking bench for quad_encoder_regs: read-map table, hand sequences for
// latency/illegal/glitch/wrap/speed corners, and random steps against a step-level model.
`timescale 1ns/1ps

module tb_quad_encoder_regs;

  localparam int SD = 100;
  localparam int FL = 4;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        EncA_L, EncB_L, EncA_R, EncB_R;
  logic [7:0]  DataAddr;
  logic [31:0] DataToRPi;
  logic        Tick;

  int n_chk  = 0;
  int n_fail = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [10];

  // Quadrature positions in forward order; index arithmetic mod 4 gives direction.
  logic [1:0] gray [4] = '{2'b00, 2'b10, 2'b11, 2'b01};

  quad_encoder_regs #(.SAMPLE_DIV(SD), .FILT_LEN(FL)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .EncA_L    (EncA_L),
    .EncB_L    (EncB_L),
    .EncA_R    (EncA_R),
    .EncB_R    (EncB_R),
    .DataAddr  (DataAddr),
    .DataToRPi (DataToRPi),
    .Tick      (Tick)
  );

  always #10 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    DataAddr = a;
    #1;
    check(name, DataToRPi, exp);
  endtask

  task automatic set_l(input logic [1:0] ab);
    {EncA_L, EncB_L} = ab;
  endtask

  task automatic set_r(input logic [1:0] ab);
    {EncA_R, EncB_R} = ab;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx_l, idx_r, d_l, d_r;
    logic [31:0] m_pos_l, m_pos_r;
    logic [15:0] m_err_l, m_err_r;

    tbl[0] = '{8'h00, 32'hCA4B0714};
    tbl[1] = '{8'h01, 32'h0};
    tbl[2] = '{8'h02, 32'h0};
    tbl[3] = '{8'h03, 32'h0};
    tbl[4] = '{8'h04, 32'h0};
    tbl[5] = '{8'h05, 32'h0};
    tbl[6] = '{8'h06, 32'h0};
    tbl[7] = '{8'h07, 32'h1};
    tbl[8] = '{8'h08, 32'h0};
    tbl[9] = '{8'hFF, 32'h0};

    // Reset and read map
    Reset = 1'b1;
    DataAddr = 8'h00;
    set_l(2'b00);
    set_r(2'b00);
    run(3);
    for (int i = 0; i < 10; i++) begin
      rd_check($sformatf("reset_rd_%02h", tbl[i].addr), tbl[i].addr, tbl[i].exp);
      check("reset_tick", {31'd0, Tick}, 32'd0);
      step();
    end

    // Rest at 11 after reset: priming only, no count, no error
    set_l(2'b11);
    set_r(2'b11);
    Reset = 1'b0;
    cyc = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      rd_check("rest11_posl", 8'h01, 32'h0);
      rd_check("rest11_err", 8'h05, 32'h0);
    end
    rd_check("rest11_primed", 8'h07, 32'h7);

    // Forward steps with exact pin-to-count latency
    idx_l = 2;
    for (int k = 0; k < 4; k++) begin
      idx_l = (idx_l + 1) % 4;
      set_l(gray[idx_l]);
      run(FL + 2);
      rd_check("lat_before", 8'h01, 32'(k));
      run(1);
      rd_check("lat_after", 8'h01, 32'(k + 1));
      run(3);
    end
    for (int k = 0; k < 8; k++) begin
      idx_l = (idx_l + 3) % 4;
      set_l(gray[idx_l]);
      run(10);
    end
    rd_check("rev_posl", 8'h01, 32'hFFFFFFFC);
    rd_check("rev_posr", 8'h02, 32'h0);

    // Illegal 11 -> 00 on the left channel
    set_l(2'b00);
    run(10);
    rd_check("illegal_posl", 8'h01, 32'hFFFFFFFC);
    rd_check("illegal_err", 8'h05, 32'h00010000);

    // 3-cycle glitch on EncA_R is filtered out
    EncA_R = 1'b0;
    run(3);
    EncA_R = 1'b1;
    run(15);
    rd_check("glitch_posl", 8'h01, 32'hFFFFFFFC);
    rd_check("glitch_posr", 8'h02, 32'h0);
    rd_check("glitch_err", 8'h05, 32'h00010000);
    rd_check("glitch_primed", 8'h07, 32'h7);

    // Position wrap at the signed maximum
    force dut.u_chan_l.pos_q = 32'h7FFFFFFF;
    step();
    release dut.u_chan_l.pos_q;
    step();
    rd_check("wrap_pre", 8'h01, 32'h7FFFFFFF);
    set_l(2'b10);
    run(10);
    rd_check("wrap_post", 8'h01, 32'h80000000);

    // Error counter saturation
    force dut.u_chan_r.err_q = 16'hFFFF;
    step();
    release dut.u_chan_r.err_q;
    step();
    set_r(2'b00);
    run(10);
    rd_check("err_sat", 8'h05, 32'h0001FFFF);

    // Random steps against a step-level model
    set_l(2'b11);
    set_r(2'b11);
    Reset = 1'b1;
    run(3);
    Reset = 1'b0;
    cyc = 0;
    run(10);
    idx_l = 2; idx_r = 2;
    m_pos_l = 32'd0; m_pos_r = 32'd0;
    m_err_l = 16'd0; m_err_r = 16'd0;
    for (int n = 0; n < 40; n++) begin
      d_l = int'($urandom_range(0, 3));
      d_r = int'($urandom_range(0, 3));
      idx_l = (idx_l + d_l) % 4;
      idx_r = (idx_r + d_r) % 4;
      if (d_l == 1) m_pos_l = m_pos_l + 32'd1;
      if (d_l == 3) m_pos_l = m_pos_l - 32'd1;
      if (d_l == 2 && m_err_l != 16'hFFFF) m_err_l = m_err_l + 16'd1;
      if (d_r == 1) m_pos_r = m_pos_r + 32'd1;
      if (d_r == 3) m_pos_r = m_pos_r - 32'd1;
      if (d_r == 2 && m_err_r != 16'hFFFF) m_err_r = m_err_r + 16'd1;
      set_l(gray[idx_l]);
      set_r(gray[idx_r]);
      run(8);
      rd_check("rand_posl", 8'h01, m_pos_l);
      rd_check("rand_posr", 8'h02, m_pos_r);
      rd_check("rand_err", 8'h05, {m_err_l, m_err_r});
    end

    // Speed windows: 12 forward right steps, last decoded on the tick edge, then 5 reverse
    set_l(2'b11);
    set_r(2'b11);
    Reset = 1'b1;
    run(3);
    Reset = 1'b0;
    cyc = 0;
    idx_r = 2;
    while (cyc < 250) begin
      for (int i = 0; i < 12; i++) begin
        if (cyc == 93 - 7 * (11 - i)) begin
          idx_r = (idx_r + 1) % 4;
          set_r(gray[idx_r]);
        end
      end
      for (int j = 0; j < 5; j++) begin
        if (cyc == 110 + 10 * j) begin
          idx_r = (idx_r + 3) % 4;
          set_r(gray[idx_r]);
        end
      end
      if (cyc == 99) begin
        check("tick_before", {31'd0, Tick}, 32'd0);
        rd_check("speed_before", 8'h04, 32'h0);
      end
      if (cyc == 100) begin
        check("tick_first", {31'd0, Tick}, 32'd1);
        rd_check("speed_w1", 8'h04, 32'd12);
        rd_check("wincnt_w1", 8'h06, 32'd1);
        rd_check("speedl_w1", 8'h03, 32'h0);
      end
      if (cyc == 101) check("tick_pulse_end", {31'd0, Tick}, 32'd0);
      if (cyc == 200) begin
        check("tick_second", {31'd0, Tick}, 32'd1);
        rd_check("speed_w2", 8'h04, 32'hFFFFFFFB);
        rd_check("wincnt_w2", 8'h06, 32'd2);
        rd_check("posr_w2", 8'h02, 32'd7);
      end
      step();
    end

    // Reset in the middle of window 3 (count 50)
    Reset = 1'b1;
    step();
    Reset = 1'b0;
    cyc = 0;
    rd_check("midrst_wincnt", 8'h06, 32'h0);
    while (cyc < 100) begin
      check("midrst_tick_low", {31'd0, Tick}, 32'd0);
      rd_check("midrst_speed", 8'h04, 32'h0);
      step();
    end
    check("midrst_tick", {31'd0, Tick}, 32'd1);
    rd_check("midrst_speed_tick", 8'h04, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
